fsm_using_always: RTL and testbench
===================================

# fsm_using_always

Two-requester round-trip arbiter FSM. It grants a single shared resource to requester 0 or requester 1. Requester 0 has fixed priority, and a grant is held for as long as its owner keeps requesting. It sits between two request sources and the shared resource, and drives mutually exclusive registered grant lines.

## Interface
- Parameters: none.
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
  - reset=0 forces the idle state immediately.
  - The port keeps the codebase name `reset` despite the low polarity.
- req_0  input  1  request from requester 0 (high priority); level-sensitive, sampled on rising edge.
- req_1  input  1  request from requester 1 (low priority); level-sensitive, sampled on rising edge.
- gnt_0  output 1  grant to requester 0; registered.
- gnt_1  output 1  grant to requester 1; registered.

## Operation
- States, one-hot encoded:
  - IDLE = 3'b001
  - GNT0 = 3'b010
  - GNT1 = 3'b100
- Transitions, evaluated at each rising clock edge while reset=1:
  - IDLE: req_0=1 → GNT0; else req_1=1 → GNT1; else stay in IDLE.
  - GNT0: req_0=1 → stay in GNT0; req_0=0 → IDLE. req_1 is ignored.
  - GNT1: req_1=1 → stay in GNT1; req_1=0 → IDLE. req_0 is ignored, so there is no preemption.
  - Illegal or unreachable encoding → IDLE on the next edge. Grants are 0 while in an illegal state.
- Outputs are Moore-style:
  - gnt_0=1 exactly when state=GNT0.
  - gnt_1=1 exactly when state=GNT1.
  - Both are 0 in IDLE.
  - gnt_0 and gnt_1 are never both 1.
- Both requests high while in IDLE: requester 0 wins.
- After any release the FSM always passes through IDLE for at least one cycle. A continuously asserted other requester is granted on the following edge.

## Timing
- Reset:
  - reset=0 asynchronously sets state=IDLE, gnt_0=0, gnt_1=0 with no clock needed.
  - Reset asserted mid-grant drops the grant immediately.
  - The first transition occurs on the first rising edge after reset returns high.
- Grant latency:
  - A request sampled at edge k in IDLE → gnt high after edge k, i.e. within the same cycle as the state change.
  - gnt and state are updated on the same edge; there is no extra output-register lag.
- Release latency: request deasserted and sampled at edge k → gnt low after edge k.
- Minimum grant duration is 1 cycle. Minimum IDLE gap between consecutive grants is 1 cycle.
- Requests must be synchronous to clock; no internal synchronizers.

## Structure
- Shared package `fsm_using_always_pkg`:
  - state width constant SIZE=3
  - state enum/localparams IDLE, GNT0, GNT1 with the one-hot values above
- Implementation:
  - one combinational next-state block
  - one sequential state register with async active-low reset
  - one sequential output-register block driven from next state
- No sub-module; the block is self-contained.

## Test plan
- Clock period 10 ns (rising edges at 5, 15, 25, …). Hold reset=0 for 0–10 ns with req_1=1, req_0=0 → gnt_0=0, gnt_1=0 throughout reset. The edge at 5 ns causes no change.
- Release reset at 10 ns, then drive req_0=1, req_1=1 → after the 15 ns edge gnt_0=1, gnt_1=0 (priority to req_0).
- req_0=0, req_1=0 at 20 ns → after the 25 ns edge gnt_0=0, gnt_1=0 (IDLE).
- req_0=1 at 30 ns, then req_0=1, req_1=1 at 40 ns → gnt_0=1 after the 35 ns edge and stays 1 after the 45 ns edge; gnt_1 stays 0 (no preemption).
- Both requests low at 50 ns → gnt_0=0 after the 55 ns edge.
- GNT1 hold and release:
  - From IDLE, assert req_1 only for 3 edges → gnt_1=1 for 3 cycles.
  - Assert req_0 while gnt_1=1 → gnt_1 stays 1.
  - Drop req_1 → IDLE for one cycle, then gnt_0=1.
- Pull reset low mid-cycle while gnt_0=1 → gnt_0=0 immediately, before the next edge.

Source files
------------

// File: rtl/fsm_using_always_pkg.sv
// rtl/fsm_using_always_pkg.sv - shared state encoding for the two-requester arbiter
package fsm_using_always_pkg;

  localparam int SIZE = 3;

  // One-hot states; any other encoding is treated as illegal and recovers to IDLE.
  typedef enum logic [SIZE-1:0] {
    IDLE = 3'b001,
    GNT0 = 3'b010,
    GNT1 = 3'b100
  } state_t;

endpackage

// File: rtl/fsm_using_always.sv
// rtl/fsm_using_always.sv - two-requester fixed-priority arbiter with registered grants
module fsm_using_always
  import fsm_using_always_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req_0,
  input  logic req_1,
  output logic gnt_0,
  output logic gnt_1
);

  state_t r_state;
  state_t w_next_state;

  // Next-state selection: req_0 wins from IDLE, an owner keeps the grant while it requests.
  always_comb begin
    w_next_state = IDLE;
    case (r_state)
      IDLE: begin
        if (req_0)      w_next_state = GNT0;
        else if (req_1) w_next_state = GNT1;
        else            w_next_state = IDLE;
      end
      GNT0: w_next_state = req_0 ? GNT0 : IDLE;
      GNT1: w_next_state = req_1 ? GNT1 : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register; reset forces IDLE without waiting for a clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Grants are registered from next state so they change on the same edge as the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt_0 <= 1'b0;
      gnt_1 <= 1'b0;
    end else begin
      gnt_0 <= (w_next_state == GNT0);
      gnt_1 <= (w_next_state == GNT1);
    end
  end

endmodule

// File: tb/tb_fsm_using_always.sv
// tb/tb_fsm_using_always.sv - scoreboard bench for the two-requester arbiter
module tb_fsm_using_always;

  logic clock;
  logic reset;
  logic req_0;
  logic req_1;
  logic gnt_0;
  logic gnt_1;

  int total;
  int bad;

  // Reference state: 0 idle, 1 granted to requester 0, 2 granted to requester 1.
  int m_state;
  logic [1:0] exp_q[$];

  fsm_using_always dut (
    .clock (clock),
    .reset (reset),
    .req_0 (req_0),
    .req_1 (req_1),
    .gnt_0 (gnt_0),
    .gnt_1 (gnt_1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int model_next(int s, logic r0, logic r1);
    case (s)
      0:       return r0 ? 1 : (r1 ? 2 : 0);
      1:       return r0 ? 1 : 0;
      2:       return r1 ? 2 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] model_gnt(int s);
    return {s == 1, s == 2};
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed={gnt_0,gnt_1}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive requests, predict, and compare just after the next rising edge.
  task automatic step(input string tag, input logic r0, input logic r1);
    logic [1:0] e;
    req_0 = r0;
    req_1 = r1;
    m_state = model_next(m_state, r0, r1);
    exp_q.push_back(model_gnt(m_state));
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check(tag, {gnt_0, gnt_1}, e);
    @(negedge clock);
  endtask

  // Grants must never overlap, sampled away from the active edge.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      total++;
      assert (!(gnt_0 === 1'b1 && gnt_1 === 1'b1))
      else begin
        bad++;
        $error("FAIL exclusive observed={gnt_0,gnt_1}=%b expected=not 11", {gnt_0, gnt_1});
      end
    end
  end

  initial begin
    total   = 0;
    bad     = 0;
    m_state = 0;
    reset   = 1'b0;
    req_0   = 1'b0;
    req_1   = 1'b1;

    #2;
    check("reset_t2", {gnt_0, gnt_1}, 2'b00);
    #5;
    check("reset_edge5", {gnt_0, gnt_1}, 2'b00);
    @(negedge clock);
    reset = 1'b1;

    step("both_prio0", 1'b1, 1'b1);
    check("prio0_const", {gnt_0, gnt_1}, 2'b10);
    step("release_idle", 1'b0, 1'b0);
    check("idle_const", {gnt_0, gnt_1}, 2'b00);
    step("req0_grant", 1'b1, 1'b0);
    step("no_preempt0", 1'b1, 1'b1);
    check("no_preempt0_const", {gnt_0, gnt_1}, 2'b10);
    step("release0", 1'b0, 1'b0);

    step("gnt1_c1", 1'b0, 1'b1);
    check("gnt1_c1_const", {gnt_0, gnt_1}, 2'b01);
    step("gnt1_c2", 1'b0, 1'b1);
    step("gnt1_c3", 1'b0, 1'b1);
    step("no_preempt1", 1'b1, 1'b1);
    check("no_preempt1_const", {gnt_0, gnt_1}, 2'b01);
    step("gap_idle", 1'b1, 1'b0);
    check("gap_idle_const", {gnt_0, gnt_1}, 2'b00);
    step("then_gnt0", 1'b1, 1'b0);
    check("then_gnt0_const", {gnt_0, gnt_1}, 2'b10);

    // Reset mid-cycle while requester 0 holds the grant.
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_drop", {gnt_0, gnt_1}, 2'b00);
    m_state = 0;
    @(posedge clock);
    #1;
    check("reset_held_edge", {gnt_0, gnt_1}, 2'b00);
    @(negedge clock);
    reset = 1'b1;
    step("post_reset_gnt1", 1'b0, 1'b1);
    step("gnt1_release", 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      step("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    total++;
    assert (exp_q.size() == 0)
    else begin
      bad++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
